// File: rtl/adc_spi_pkg.sv
// Shared types and AD9648 SPI instruction layout for the ADC init sequencer.
// The verify states only exist when READBACK_VERIFY_EN is defined.
package adc_spi_pkg;

    localparam int unsigned RW_BIT   = 23;
    localparam int unsigned W_MSB    = 22;
    localparam int unsigned W_LSB    = 21;
    localparam int unsigned ADDR_MSB = 20;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    localparam logic [12:0] TRANSFER_REG_ADDR = 13'h0FF;
    localparam logic [7:0]  TRANSFER_UPDATE   = 8'h01;

    typedef enum logic [3:0] {
        StIdle,
        StPwrWait,
        StIssueWr,
        StWaitWr,
        StNext,
        StIssueUpd,
        StWaitUpd,
        StDone,
        StError,
        StHostIssue,
        StHostWait,
        StHostAck
`ifdef READBACK_VERIFY_EN
        ,
        StIssueRd,
        StWaitRd,
        StCheck
`endif
    } state_e;

    function automatic logic [23:0] write_word(input logic [12:0] addr, input logic [7:0] data);
        logic [23:0] w;
        w                     = '0;
        w[RW_BIT]             = 1'b0;
        w[W_MSB:W_LSB]        = 2'b00;
        w[ADDR_MSB:ADDR_LSB]  = addr;
        w[DATA_MSB:DATA_LSB]  = data;
        return w;
    endfunction

    function automatic logic [23:0] read_word(input logic [12:0] addr);
        logic [23:0] w;
        w                     = '0;
        w[RW_BIT]             = 1'b1;
        w[W_MSB:W_LSB]        = 2'b00;
        w[ADDR_MSB:ADDR_LSB]  = addr;
        return w;
    endfunction

endpackage

// File: rtl/adc_init_rom.sv
// Fixed AD9648 power-up command table, indexed combinationally.
module adc_init_rom
    import adc_spi_pkg::*;
#(
    parameter int unsigned IdxW = 3
) (
    input  logic [IdxW-1:0] idx_i,
    output logic [23:0]     word_o
);

    always_comb begin
        word_o = '0;
        case (idx_i)
            IdxW'(0): word_o = write_word(13'h000, 8'h3C);  // soft reset
            IdxW'(1): word_o = write_word(13'h014, 8'h01);  // output mode
            IdxW'(2): word_o = write_word(13'h00B, 8'h01);  // clock divide
            IdxW'(3): word_o = write_word(13'h016, 8'hA5);
            IdxW'(4): word_o = write_word(13'h018, 8'h04);
            IdxW'(5): word_o = write_word(13'h101, 8'h80);
            IdxW'(6): word_o = write_word(13'h102, 8'h00);
            IdxW'(7): word_o = write_word(13'h008, 8'h00);
            default:  word_o = '0;
        endcase
    end

endmodule

// File: rtl/adc_spi_init_sequencer.sv
// Walks the AD9648 init table over the SPI config path, commits with a transfer update, then
// arbitrates host accesses. READBACK_VERIFY_EN adds read-back checking with retries.
module adc_spi_init_sequencer
    import adc_spi_pkg::*;
#(
    parameter int unsigned TxRegWidth    = 24,
    parameter int unsigned RxRegWidth    = 8,
    parameter int unsigned NumCmds       = 8,
    parameter int unsigned PowerUpCycles = 1024,
    parameter int unsigned TimeoutCycles = 4096
`ifdef READBACK_VERIFY_EN
    ,
    parameter int unsigned MaxRetries    = 2
`endif
) (
    input  logic                         clk_i,
    input  logic                         rst_clk_i,
    input  logic                         start_i,
    output logic [TxRegWidth-1:0]        tx_reg_o,
    output logic                         transfer_start_o,
    input  logic [RxRegWidth-1:0]        rx_reg_i,
    input  logic                         transfer_done_i,
    input  logic                         host_req_i,
    input  logic [TxRegWidth-1:0]        host_tx_reg_i,
    output logic                         host_ack_o,
    output logic [RxRegWidth-1:0]        host_rx_reg_o,
    output logic                         config_done_o,
    output logic                         busy_o,
    output logic                         error_o,
    output logic [$clog2(NumCmds+1)-1:0] err_idx_o
);

    localparam int unsigned IdxW   = (NumCmds > 1) ? $clog2(NumCmds) : 1;
    localparam int unsigned ErrW   = $clog2(NumCmds + 1);
    localparam int unsigned CntMax = (PowerUpCycles > TimeoutCycles) ? PowerUpCycles
                                                                     : TimeoutCycles;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  config_done_q, config_done_d;
    logic                  error_q, error_d;
    logic [ErrW-1:0]       err_idx_q, err_idx_d;
    logic [TxRegWidth-1:0] host_word_q, host_word_d;
    logic [RxRegWidth-1:0] host_rx_q, host_rx_d;
`ifdef READBACK_VERIFY_EN
    localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    logic [RetryW-1:0]     retry_q, retry_d;
    logic [RxRegWidth-1:0] rd_data_q, rd_data_d;
`endif

    logic [23:0]           rom_word;
    logic [TxRegWidth-1:0] tx_word;
    logic                  xfer_start;
    logic                  timeout;

    adc_init_rom #(
        .IdxW (IdxW)
    ) u_rom (
        .idx_i  (idx_q),
        .word_o (rom_word)
    );

    assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));

    always_comb begin
        tx_word = '0;
        case (state_q)
            StIssueWr, StWaitWr:     tx_word = TxRegWidth'(rom_word);
            StIssueUpd, StWaitUpd:   tx_word = TxRegWidth'(write_word(TRANSFER_REG_ADDR,
                                                                  TRANSFER_UPDATE));
`ifdef READBACK_VERIFY_EN
            StIssueRd, StWaitRd:     tx_word = TxRegWidth'(read_word(
                                                   rom_word[ADDR_MSB:ADDR_LSB]));
`endif
            StHostIssue, StHostWait: tx_word = host_word_q;
            default:                 tx_word = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        config_done_d = config_done_q;
        error_d       = error_q;
        err_idx_d     = err_idx_q;
        host_word_d   = host_word_q;
        host_rx_d     = host_rx_q;
        xfer_start    = 1'b0;
`ifdef READBACK_VERIFY_EN
        retry_d       = retry_q;
        rd_data_d     = rd_data_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StPwrWait;
                    cnt_d   = '0;
                end
            end
            StPwrWait: begin
                if (cnt_q == CntW'(PowerUpCycles)) begin
                    state_d = StIssueWr;
                    idx_d   = '0;
`ifdef READBACK_VERIFY_EN
                    retry_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIssueWr: begin
                xfer_start = 1'b1;
                cnt_d      = '0;
                state_d    = StWaitWr;
            end
            StWaitWr: begin
                if (transfer_done_i) begin
`ifdef READBACK_VERIFY_EN
                    state_d = StIssueRd;
`else
                    state_d = StNext;
`endif
                end else if (timeout) begin
                    state_d   = StError;
                    error_d   = 1'b1;
                    err_idx_d = ErrW'(idx_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef READBACK_VERIFY_EN
            StIssueRd: begin
                xfer_start = 1'b1;
                cnt_d      = '0;
                state_d    = StWaitRd;
            end
            StWaitRd: begin
                if (transfer_done_i) begin
                    rd_data_d = rx_reg_i;
                    state_d   = StCheck;
                end else if (timeout) begin
                    state_d   = StError;
                    error_d   = 1'b1;
                    err_idx_d = ErrW'(idx_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                if (rd_data_q == RxRegWidth'(rom_word[DATA_MSB:DATA_LSB])) begin
                    state_d = StNext;
                end else if (retry_q < RetryW'(MaxRetries)) begin
                    retry_d = retry_q + 1'b1;
                    state_d = StIssueWr;
                end else begin
                    state_d   = StError;
                    error_d   = 1'b1;
                    err_idx_d = ErrW'(idx_q);
                end
            end
`endif
            StNext: begin
                if (idx_q == IdxW'(NumCmds - 1)) begin
                    state_d = StIssueUpd;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StIssueWr;
`ifdef READBACK_VERIFY_EN
                    retry_d = '0;
`endif
                end
            end
            StIssueUpd: begin
                xfer_start = 1'b1;
                cnt_d      = '0;
                state_d    = StWaitUpd;
            end
            StWaitUpd: begin
                if (transfer_done_i) begin
                    state_d       = StDone;
                    config_done_d = 1'b1;
                end else if (timeout) begin
                    state_d   = StError;
                    error_d   = 1'b1;
                    err_idx_d = ErrW'(NumCmds);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone, StError: begin
                // A restart wins over a simultaneous host request; the host keeps it pending.
                if (start_i) begin
                    state_d       = StPwrWait;
                    cnt_d         = '0;
                    config_done_d = 1'b0;
                    error_d       = 1'b0;
                    err_idx_d     = '0;
                end else if (host_req_i) begin
                    host_word_d = host_tx_reg_i;
                    state_d     = StHostIssue;
                end
            end
            StHostIssue: begin
                xfer_start = 1'b1;
                cnt_d      = '0;
                state_d    = StHostWait;
            end
            StHostWait: begin
                if (transfer_done_i) begin
                    host_rx_d = rx_reg_i;
                    state_d   = StHostAck;
                end else if (timeout) begin
                    host_rx_d = '1;
                    state_d   = StHostAck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHostAck: begin
                state_d = error_q ? StError : StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_clk_i) begin
        if (!rst_clk_i) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            cnt_q         <= '0;
            config_done_q <= 1'b0;
            error_q       <= 1'b0;
            err_idx_q     <= '0;
            host_word_q   <= '0;
            host_rx_q     <= '0;
`ifdef READBACK_VERIFY_EN
            retry_q       <= '0;
            rd_data_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            config_done_q <= config_done_d;
            error_q       <= error_d;
            err_idx_q     <= err_idx_d;
            host_word_q   <= host_word_d;
            host_rx_q     <= host_rx_d;
`ifdef READBACK_VERIFY_EN
            retry_q       <= retry_d;
            rd_data_q     <= rd_data_d;
`endif
        end
    end

    assign tx_reg_o         = tx_word;
    assign transfer_start_o = xfer_start;
    assign host_ack_o       = (state_q == StHostAck);
    assign host_rx_reg_o    = host_rx_q;
    assign config_done_o    = config_done_q;
    assign error_o          = error_q;
    assign err_idx_o        = err_idx_q;
    assign busy_o           = !(state_q inside {StIdle, StDone, StError});

endmodule
